uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver: next generation of the team's serial RX path. Recovers asynchronous frames with configurable word width, parity mode and stop-bit count. Majority-votes each bit at mid-bit and reports parity, framing and overrun errors per word. Buffers received words in a small FIFO behind a valid/ready handshake, so the downstream consumer may stall without losing back-to-back frames.

## Interface
- CLK_RATE, 100000000: system clock frequency, Hz.
- BAUD_RATE, 115200: line rate, baud.
- WORD_WIDTH, 8: data bits per frame (5..9).
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit; even, ≥ 8.
- FIFO_DEPTH, 4: entries; power of two, ≥ 2.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idles high.
- rx_data_out  out  WORD_WIDTH  FIFO head data; 0 when empty.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts head; pop on rx_valid && rx_ready.
- rx_parity_err  out  1  head entry parity mismatch; 0 when empty or PARITY_MODE = 0.
- rx_frame_err  out  1  head entry had a 0 stop bit; 0 when empty.
- rx_overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- rx_busy  out  1  FSM not in IDLE.

## Operation
- rx_in passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value.
- Tick generator: DIV = CLK_RATE / (BAUD_RATE*OVERSAMPLE), truncated. One-cycle tick every DIV clocks. Counter is cleared on IDLE→START so tick phase aligns to the start edge.
- Sample counter counts ticks within a bit, 0..OVERSAMPLE-1. Bit value = majority of samples at ticks M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE → START on a synchronized 0, but only when armed. Armed is set after the line has been seen high. It is cleared by a frame error and re-set after the line is high for OVERSAMPLE consecutive ticks.
  - START: at tick M+1, a voted 1 is a false start → IDLE with no push. A voted 0 → DATA at the end of the bit.
  - DATA: WORD_WIDTH bits, LSB first. Last bit → PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: voted bit compared with XOR of data (even) or XNOR of data (odd).
  - STOP: STOP_BITS bits. Any voted 0 sets the frame error.
- Push occurs at tick M+1 of the final stop bit. The FSM returns to IDLE on the same cycle, so the next start edge may arrive within the remaining half bit.
- FIFO entry = {frame_err, parity_err, data}. Push while full drops the frame and sets rx_overrun.
- Push and pop on the same cycle while full: both take effect, no overrun.
- rx_overrun clears on rst or on the next pop handshake.

## Timing
- Reset values: rx_valid 0, rx_data_out 0, rx_parity_err 0, rx_frame_err 0, rx_overrun 0, rx_busy 0. FIFO empty, FSM IDLE, armed 1.
- rst mid-frame aborts the frame with no push and flushes the FIFO. Effective on the next edge.
- Latency: rx_valid rises on the cycle after the push cycle. Data, flags and valid are registered FIFO-head outputs (show-ahead).
- With rx_ready held high, each word is valid for exactly one cycle.
- rx_data_out and flags are stable while rx_valid && !rx_ready.
- rx_busy rises on the cycle after the start edge is detected and falls on the cycle after the push or false-start.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - a divisor function DIV(CLK_RATE, BAUD_RATE, OVERSAMPLE).
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, with ports push, din, full, pop, dout, empty.
- Synchronizer, tick generator, voter and FSM stay in uart_rx_os.

## Test plan
All scenarios use CLK_RATE = 1600000, BAUD_RATE = 10000, OVERSAMPLE = 16, giving DIV = 10 and 160 clocks per bit.
- 8N1, rx_ready = 1, send 0xA5 → one rx_valid pulse, rx_data_out = 0xA5, both error flags 0.
- PARITY_MODE = 1, send 0x03 with parity bit 1 → rx_data_out = 0x03, rx_parity_err = 1. Resend with parity 0 → rx_parity_err = 0.
- rx_in low for 30 clocks, then high → no push, rx_busy falls, FSM back in IDLE.
- 0x00 with stop bit 0, line held low for 5 bit times → one word with rx_frame_err = 1, no further starts. After line high for 160 clocks, 0x42 is received cleanly.
- rx_ready = 0, send 0x10..0x14 → 0x10..0x13 buffered, 0x14 dropped, rx_overrun = 1. Raise rx_ready → 0x10..0x13 popped in order, rx_overrun 0 after the first pop.
- STOP_BITS = 2, frames 0x55 and 0xAA with no idle gap → both received in order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Clocks per oversampling tick, truncated; never below one so the tick still fires.
  function automatic int unsigned DIV(input int unsigned clk_rate,
                                      input int unsigned baud_rate,
                                      input int unsigned oversample);
    int unsigned d;
    d = clk_rate / (baud_rate * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head word is presented while non-empty, zero when empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronizer, tick generator, 3-sample voter and frame FSM
// feeding a small FIFO of {frame_err, parity_err, data} words.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 100000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [WORD_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int unsigned DIVISOR = DIV(CLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned BW      = $clog2(WORD_WIDTH);
  localparam int unsigned MID     = OVERSAMPLE / 2;
  localparam int unsigned EW      = WORD_WIDTH + 2;

  rx_state_t state, state_next;

  logic                  sync1, sync2, rx;
  logic [DW-1:0]         div_cnt;
  logic                  tick;
  logic [SW-1:0]         s_cnt;
  logic                  samp_a, samp_b, vote, vote_at, bit_end;
  logic [WORD_WIDTH-1:0] shift;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx, last_stop;
  logic                  par_err, frm_err, frame_now, parity_exp;
  logic                  armed;
  logic [SW-1:0]         hi_cnt;
  logic                  start_go, push, full, empty, pop_fire, drop;
  logic [EW-1:0]         head;

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end
  assign rx = sync2;

  assign tick = (div_cnt == DW'(DIVISOR - 1));

  always_ff @(posedge clock) begin
    if (rst || start_go || tick) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst || start_go)  s_cnt <= '0;
    else if (tick)        s_cnt <= (s_cnt == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (tick && s_cnt == SW'(MID - 1)) samp_a <= rx;
      if (tick && s_cnt == SW'(MID))     samp_b <= rx;
    end
  end

  // The third sample is the live line at tick M+1, so the vote resolves on that tick.
  assign vote       = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);
  assign vote_at    = tick && (s_cnt == SW'(MID + 1));
  assign bit_end    = tick && (s_cnt == SW'(OVERSAMPLE - 1));
  assign last_stop  = (STOP_BITS == 1) || stop_idx;
  assign parity_exp = (PARITY_MODE == PARITY_ODD) ? ~^shift : ^shift;
  assign frame_now  = frm_err | ~vote;

  always_ff @(posedge clock) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (armed && !rx) state_next = S_START;
      S_START:  if (vote_at && vote) state_next = S_IDLE;
                else if (bit_end)    state_next = S_DATA;
      S_DATA:   if (bit_end && bit_idx == BW'(WORD_WIDTH - 1))
                  state_next = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (vote_at && last_stop) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_go = 1'b0;
    push     = 1'b0;
    rx_busy  = (state != S_IDLE);
    case (state)
      S_IDLE:  start_go = armed && !rx;
      S_STOP:  push     = vote_at && last_stop;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (start_go) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_err  <= 1'b0;
        frm_err  <= 1'b0;
      end
      if (state == S_DATA && vote_at)   shift   <= {vote, shift[WORD_WIDTH-1:1]};
      if (state == S_DATA && bit_end)   bit_idx <= bit_idx + 1'b1;
      if (state == S_PARITY && vote_at) par_err <= vote ^ parity_exp;
      if (state == S_STOP && vote_at && !vote) frm_err <= 1'b1;
      if (state == S_STOP && bit_end)   stop_idx <= 1'b1;
    end
  end

  // After a framing error the line must idle high for a full bit of ticks before re-arming.
  always_ff @(posedge clock) begin
    if (rst) begin
      armed  <= 1'b1;
      hi_cnt <= '0;
    end else begin
      if (!rx || armed) hi_cnt <= '0;
      else if (tick)    hi_cnt <= hi_cnt + 1'b1;
      if (push && frame_now)
        armed <= 1'b0;
      else if (!armed && rx && tick && hi_cnt == SW'(OVERSAMPLE - 1))
        armed <= 1'b1;
    end
  end

  assign pop_fire = rx_valid && rx_ready;
  assign drop     = push && full && !pop_fire;

  always_ff @(posedge clock) begin
    if (rst)           rx_overrun <= 1'b0;
    else if (drop)     rx_overrun <= 1'b1;
    else if (pop_fire) rx_overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .din   ({frame_now, par_err, shift}),
    .full  (full),
    .pop   (rx_ready),
    .dout  (head),
    .empty (empty)
  );

  assign rx_valid      = !empty;
  assign rx_data_out   = head[WORD_WIDTH-1:0];
  assign rx_parity_err = head[WORD_WIDTH];
  assign rx_frame_err  = head[WORD_WIDTH+1];

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, even-parity and two-stop-bit instances on separate lines.
module tb_uart_rx_os;

  localparam int unsigned CLK_RATE = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT      = 160;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst;
  logic rx_a, rx_b, rx_c;
  logic ready_a, ready_b, ready_c;
  logic [7:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .WORD_WIDTH(8), .PARITY_MODE(0),
               .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .rst(rst), .rx_in(rx_a), .rx_data_out(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a));

  uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .WORD_WIDTH(8), .PARITY_MODE(1),
               .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .rst(rst), .rx_in(rx_b), .rx_data_out(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b));

  uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .WORD_WIDTH(8), .PARITY_MODE(0),
               .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut_c (
    .clock(clock), .rst(rst), .rx_in(rx_c), .rx_data_out(data_c), .rx_valid(valid_c),
    .rx_ready(ready_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c),
    .rx_overrun(ovr_c), .rx_busy(busy_c));

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vcount_a = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] q_c[$];

  // Words accepted by each consumer, packed {frame_err, parity_err, data}.
  always @(negedge clock) begin
    if (valid_a) vcount_a++;
    if (valid_a && ready_a) q_a.push_back({ferr_a, perr_a, data_a});
    if (valid_b && ready_b) q_b.push_back({ferr_b, perr_b, data_b});
    if (valid_c && ready_c) q_c.push_back({ferr_c, perr_c, data_c});
  end

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int unsigned which, input string name, input logic [9:0] exp);
    logic [9:0] got;
    bit         have;
    have = 1'b0;
    got  = '0;
    case (which)
      0: if (q_a.size() > 0) begin got = q_a.pop_front(); have = 1'b1; end
      1: if (q_b.size() > 0) begin got = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin got = q_c.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: no word received, expected %0h", name, exp);
    end else if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_line(input int unsigned which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold_bit(input int unsigned which, input logic v, input int unsigned clocks);
    set_line(which, v);
    repeat (clocks) @(negedge clock);
  endtask

  task automatic send_frame(input int unsigned which, input logic [7:0] data, input bit use_par,
                            input logic par_bit, input int unsigned nstop, input logic stop_val,
                            input int unsigned gap_bits);
    hold_bit(which, 1'b0, BIT);
    for (int unsigned i = 0; i < 8; i++) hold_bit(which, data[i], BIT);
    if (use_par) hold_bit(which, par_bit, BIT);
    for (int unsigned i = 0; i < nstop; i++) hold_bit(which, stop_val, BIT);
    if (gap_bits > 0) hold_bit(which, 1'b1, gap_bits * BIT);
  endtask

  initial begin
    int unsigned v0;
    //         data   par   stop  perr  ferr
    vecs[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (4) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("reset valid", valid_a, 0);
    check("reset data", data_a, 0);
    check("reset perr", perr_a, 0);
    check("reset ferr", ferr_a, 0);
    check("reset overrun", ovr_a, 0);
    check("reset busy", busy_a, 0);

    // 8N1 single word with consumer always ready
    v0 = vcount_a;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1);
    check("8n1 valid cycles", vcount_a - v0, 1);
    expect_word(0, "8n1 a5", 10'h0A5);

    // false start: 30 clocks low
    hold_bit(0, 1'b0, 10);
    check("false start busy rise", busy_a, 1);
    hold_bit(0, 1'b0, 20);
    hold_bit(0, 1'b1, 200);
    check("false start busy fall", busy_a, 0);
    check("false start no word", q_a.size(), 0);
    check("false start valid", valid_a, 0);

    // framing error followed by a long low line, then re-arm
    send_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 0);
    hold_bit(0, 1'b0, 5 * BIT);
    check("low line no restart", busy_a, 0);
    check("frame err word count", q_a.size(), 1);
    expect_word(0, "frame err word", 10'h200);
    hold_bit(0, 1'b1, 170);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1, 1'b1, 1);
    expect_word(0, "rearm 42", 10'h042);

    // overrun: five frames into a four-entry FIFO with consumer stalled
    @(posedge clock); #1 ready_a = 1'b0;
    @(negedge clock);
    for (int unsigned k = 0; k < 5; k++)
      send_frame(0, 8'(8'h10 + k), 1'b0, 1'b0, 1, 1'b1, 1);
    check("overrun valid", valid_a, 1);
    check("overrun head", data_a, 8'h10);
    check("overrun flag", ovr_a, 1);
    repeat (5) @(negedge clock);
    check("stalled head stable", data_a, 8'h10);
    check("stalled no pop", q_a.size(), 0);
    @(posedge clock); #1 ready_a = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("overrun clear after pop", ovr_a, 0);
    repeat (10) @(negedge clock);
    for (int unsigned k = 0; k < 4; k++)
      expect_word(0, $sformatf("drain %0d", k), 10'(10'h010 + k));
    check("dropped word absent", q_a.size(), 0);
    check("drained valid", valid_a, 0);

    // even parity table
    for (int unsigned i = 0; i < 7; i++) begin
      send_frame(1, vecs[i].data, 1'b1, vecs[i].par_bit, 1, vecs[i].stop_bit,
                 vecs[i].stop_bit ? 1 : 3);
      expect_word(1, $sformatf("parity vec %0d", i),
                  {vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].data});
    end

    // two stop bits, back-to-back frames
    send_frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b1, 0);
    send_frame(2, 8'hAA, 1'b0, 1'b0, 2, 1'b1, 1);
    expect_word(2, "2stop 55", 10'h055);
    expect_word(2, "2stop aa", 10'h0AA);

    // reset mid-frame flushes FIFO and aborts the frame
    @(posedge clock); #1 ready_a = 1'b0;
    @(negedge clock);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1, 1'b1, 1);
    check("held before reset", valid_a, 1);
    hold_bit(0, 1'b0, BIT);
    hold_bit(0, 1'b1, BIT);
    hold_bit(0, 1'b1, BIT);
    hold_bit(0, 1'b0, BIT);
    check("busy mid frame", busy_a, 1);
    rx_a = 1'b1;
    rst  = 1'b1;
    @(negedge clock);
    check("reset flush valid", valid_a, 0);
    check("reset flush data", data_a, 0);
    check("reset abort busy", busy_a, 0);
    rst = 1'b0;
    hold_bit(0, 1'b1, 2 * BIT);
    check("no push after abort", valid_a, 0);
    check("idle after abort", busy_a, 0);
    ready_a = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
